sha256_digest_unloader: RTL and testbench

Read-out end of the SHA-256 datapath register interface. Captures the final hash (H0..H7) in a single cycle when the core pulses load. Then streams the hash out one 32-bit word per transfer over a valid/ready handshake, H0 first. Sits between the SHA-256 core's hash registers and the host/bus read side.

---
 rtl/sha256_digest_unloader_if.sv | 23 ++
 rtl/sha256_digest_unloader.sv | 95 +++++++++
 tb/tb_sha256_digest_unloader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sha256_digest_unloader_if.sv
// Handshake bundle between the SHA-256 hash registers, the digest unloader and the host read side.
// The master modport is the unloader's view; the slave modport is the core/host side.
interface sha256_digest_unloader_if;
   logic         load;
   logic [255:0] digest_i;
   logic         out_ready;
   logic         out_valid;
   logic [31:0]  out_data;
   logic [2:0]   out_idx;
   logic         out_last;
   logic         busy_o;
   logic         overrun_o;

   modport master (
      input  load, digest_i, out_ready,
      output out_valid, out_data, out_idx, out_last, busy_o, overrun_o
   );

   modport slave (
      output load, digest_i, out_ready,
      input  out_valid, out_data, out_idx, out_last, busy_o, overrun_o
   );
endinterface

// File: rtl/sha256_digest_unloader.sv
// Captures a 256-bit SHA-256 digest on load and streams it out H0..H7 over valid/ready.
// Optional macro SHA_DIGEST_BSWAP_EN byte-reverses every output word for a little-endian host.
module sha256_digest_unloader #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   sha256_digest_unloader_if.master   bus
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]                          state_q, state_d;
   logic [NUM_WORDS-1:0][WORD_W-1:0]    buf_q, buf_d;
   logic [IDX_W-1:0]                    idx_q, idx_d;
   logic                                ovr_q, ovr_d;

   logic              send;
   logic              xfer;
   logic              final_xfer;
   logic              accept;
   logic              drop;
   logic [WORD_W-1:0] word;

   function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   always_comb begin
      send       = (state_q == ST_SEND);
      xfer       = send && bus.out_ready;
      final_xfer = xfer && (idx_q == LAST_IDX);
      // A load is taken when idle, or when it coincides with the last word leaving.
      accept     = bus.load && (!send || final_xfer);
      drop       = bus.load && send && !final_xfer;
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      ovr_d   = ovr_q;
      if (accept) begin
         buf_d   = bus.digest_i;
         idx_d   = '0;
         state_d = ST_SEND;
         ovr_d   = 1'b0;
      end else if (final_xfer) begin
         idx_d   = '0;
         state_d = ST_IDLE;
      end else if (xfer) begin
         idx_d   = idx_q + 1'b1;
      end
      if (drop) begin
         ovr_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         idx_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         idx_q   <= idx_d;
         ovr_q   <= ovr_d;
      end
   end

   // H0 occupies the most significant word of the packed buffer.
   always_comb begin
      word = buf_q[LAST_IDX - idx_q];
   end

`ifdef SHA_DIGEST_BSWAP_EN
   assign bus.out_data = bswap32(word);
`else
   assign bus.out_data = word;
`endif

   assign bus.out_valid = send;
   assign bus.busy_o    = send;
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = send && (idx_q == LAST_IDX);
   assign bus.overrun_o = ovr_q;

endmodule

// File: tb/tb_sha256_digest_unloader.sv
// Randomized scoreboard bench for sha256_digest_unloader: a word-queue model predicts the stream.
module tb_sha256_digest_unloader;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   sha256_digest_unloader_if bus();

   sha256_digest_unloader #(.WORD_W(32), .NUM_WORDS(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic [2:0]  idx;
   } exp_t;

   exp_t        sb_q[$];
   logic        exp_ovr = 1'b0;
   int          checks  = 0;
   int          errors  = 0;

   localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

   function automatic logic [31:0] exp_word(input logic [255:0] d, input int k);
      logic [31:0] w;
      w = d[255 - 32*k -: 32];
`ifdef SHA_DIGEST_BSWAP_EN
      w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
      return w;
   endfunction

   function automatic logic [255:0] rnd_digest();
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: compare current outputs with the model, then apply this cycle's inputs to it.
   initial begin
      forever begin
         @(negedge CLK);
         if (RST) begin
            sb_q.delete();
            exp_ovr = 1'b0;
            chk("rst_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_data", bus.out_data, 32'd0);
            chk("rst_ovr", 32'(bus.overrun_o), 32'd0);
         end else begin
            chk("valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
            chk("busy", 32'(bus.busy_o), 32'(sb_q.size() != 0));
            chk("overrun", 32'(bus.overrun_o), 32'(exp_ovr));
            if (sb_q.size() != 0) begin
               chk("data", bus.out_data, sb_q[0].data);
               chk("idx", 32'(bus.out_idx), 32'(sb_q[0].idx));
               chk("last", 32'(bus.out_last), 32'(sb_q[0].idx == 3'd7));
               if (bus.out_ready) void'(sb_q.pop_front());
            end else begin
               chk("idle_last", 32'(bus.out_last), 32'd0);
            end
            if (bus.load) begin
               if (sb_q.size() == 0) begin
                  for (int k = 0; k < 8; k++) sb_q.push_back('{exp_word(bus.digest_i, k), 3'(k)});
                  exp_ovr = 1'b0;
               end else begin
                  exp_ovr = 1'b1;
               end
            end
         end
      end
   end

   task automatic cyc(input logic ld, input logic [255:0] d, input logic rdy);
      @(posedge CLK);
      #1;
      bus.load      = ld;
      bus.digest_i  = d;
      bus.out_ready = rdy;
   endtask

   task automatic wait_idle(input int lim);
      int n;
      n = 0;
      while (bus.busy_o && n < lim) begin
         cyc(1'b0, '0, 1'b1);
         n++;
      end
      checks++;
      if (n >= lim) begin
         errors++;
         $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
      end
   endtask

   logic [255:0] a, b;

   initial begin
      bus.load      = 1'b0;
      bus.digest_i  = '0;
      bus.out_ready = 1'b0;
      #2;
      chk("reset_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_idx", 32'(bus.out_idx), 32'd0);
      chk("reset_last", 32'(bus.out_last), 32'd0);
      chk("reset_busy", 32'(bus.busy_o), 32'd0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // "abc" digest, ready held high
      cyc(1'b1, ABC, 1'b1);
      repeat (12) cyc(1'b0, '0, 1'b1);
      wait_idle(20);

      // "abc" with ready pattern 1,0,0
      cyc(1'b1, ABC, 1'b1);
      for (int i = 0; i < 30; i++) cyc(1'b0, '0, (i % 3) == 0);
      wait_idle(40);

      // load dropped during word 3, then accepted once idle
      a = rnd_digest();
      b = rnd_digest();
      cyc(1'b1, a, 1'b1);
      repeat (3) cyc(1'b0, '0, 1'b1);
      cyc(1'b1, b, 1'b1);
      repeat (8) cyc(1'b0, '0, 1'b1);
      cyc(1'b1, b, 1'b1);
      repeat (10) cyc(1'b0, '0, 1'b1);
      wait_idle(20);

      // load coinciding with the final transfer
      a = rnd_digest();
      b = rnd_digest();
      cyc(1'b1, a, 1'b1);
      repeat (7) cyc(1'b0, '0, 1'b1);
      cyc(1'b1, b, 1'b1);
      repeat (10) cyc(1'b0, '0, 1'b1);
      wait_idle(20);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 7) == 0), rnd_digest(), ($urandom_range(0, 2) != 0));
      end
      cyc(1'b0, '0, 1'b1);
      wait_idle(20);

      // reset mid-stream while stalled at idx 4, with a dropped load beforehand
      a = rnd_digest();
      cyc(1'b1, a, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b1, rnd_digest(), 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);
      #2;
      chk("pre_rst_idx", 32'(bus.out_idx), 32'd4);
      chk("pre_rst_ovr", 32'(bus.overrun_o), 32'd1);
      RST = 1'b1;
      #1;
      chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst_data", bus.out_data, 32'd0);
      chk("async_rst_idx", 32'(bus.out_idx), 32'd0);
      chk("async_rst_last", 32'(bus.out_last), 32'd0);
      chk("async_rst_busy", 32'(bus.busy_o), 32'd0);
      chk("async_rst_ovr", 32'(bus.overrun_o), 32'd0);
      repeat (2) cyc(1'b0, '0, 1'b1);
      RST = 1'b0;
      repeat (6) cyc(1'b0, '0, 1'b1);
      cyc(1'b1, ABC, 1'b1);
      repeat (10) cyc(1'b0, '0, 1'b1);
      wait_idle(20);

      @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
